mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of every request, response and ROM-side signal of the two-port ROM arbiter.
// The arbiter uses the slave view; requesters and the ROM use the master view.
`timescale 1ns/1ps
interface mem_arbiter_if #(
  parameter int AW    = 4,
  parameter int EXTRA = 4
);
  localparam int DW = (2**EXTRA)*8;

  logic             req0;
  logic             req1;
  logic [AW:0]      addr0;
  logic [AW:0]      addr1;
  logic [EXTRA-1:0] extra0;
  logic [EXTRA-1:0] extra1;
  logic [AW:0]      lo0;
  logic [AW:0]      lo1;
  logic [AW:0]      hi0;
  logic [AW:0]      hi1;
  logic             rvalid0;
  logic             rvalid1;
  logic [DW-1:0]    rdata0;
  logic [DW-1:0]    rdata1;
  logic             rerror0;
  logic             rerror1;
  logic [AW:0]      mem_addr;
  logic [EXTRA-1:0] mem_extra;
  logic [AW:0]      mem_lower_bound;
  logic [AW:0]      mem_upper_bound;
  logic [DW-1:0]    mem_data;
  logic             mem_error;
  logic             busy;
  logic [1:0]       grant;

  modport slave (
    input  req0, req1, addr0, addr1, extra0, extra1, lo0, lo1, hi0, hi1,
    input  mem_data, mem_error,
    output rvalid0, rvalid1, rdata0, rdata1, rerror0, rerror1,
    output mem_addr, mem_extra, mem_lower_bound, mem_upper_bound,
    output busy, grant
  );

  modport master (
    output req0, req1, addr0, addr1, extra0, extra1, lo0, lo1, hi0, hi1,
    output mem_data, mem_error,
    input  rvalid0, rvalid1, rdata0, rdata1, rerror0, rerror1,
    input  mem_addr, mem_extra, mem_lower_bound, mem_upper_bound,
    input  busy, grant
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-cycle-latency ROM between a fetch port (0)
// and a data port (1); one access in flight, IDLE -> ISSUE -> RESP.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int AW    = 4,
  parameter int EXTRA = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam int DW = (2**EXTRA)*8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_grant;
  logic [1:0]       w_grant_next;
  logic             r_last;
  logic             w_last_next;
  logic [AW:0]      r_addr;
  logic [AW:0]      w_addr_next;
  logic [EXTRA-1:0] r_extra;
  logic [EXTRA-1:0] w_extra_next;
  logic [AW:0]      r_lo;
  logic [AW:0]      w_lo_next;
  logic [AW:0]      r_hi;
  logic [AW:0]      w_hi_next;

  logic [1:0]       w_req;
  logic [AW:0]      w_addr  [2];
  logic [EXTRA-1:0] w_extra [2];
  logic [AW:0]      w_lo    [2];
  logic [AW:0]      w_hi    [2];
  logic [1:0]       w_rvalid;
  logic [1:0]       w_rerror;
  logic [DW-1:0]    w_rdata [2];
  logic             w_win;
  logic             w_other;

  assign w_req      = {bus.req1, bus.req0};
  assign w_addr[0]  = bus.addr0;
  assign w_addr[1]  = bus.addr1;
  assign w_extra[0] = bus.extra0;
  assign w_extra[1] = bus.extra1;
  assign w_lo[0]    = bus.lo0;
  assign w_lo[1]    = bus.lo1;
  assign w_hi[0]    = bus.hi0;
  assign w_hi[1]    = bus.hi1;

  // r_last = 1 means port 1 was granted last, so port 0 wins a tie.
  assign w_win   = (w_req == 2'b11) ? ~r_last : w_req[1];
  // In RESP the port not being served is the only candidate for the next grant.
  assign w_other = r_grant[0];

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_last_next  = r_last;
    w_addr_next  = r_addr;
    w_extra_next = r_extra;
    w_lo_next    = r_lo;
    w_hi_next    = r_hi;
    case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_state_next = ISSUE;
          w_grant_next = w_win ? 2'b10 : 2'b01;
          w_last_next  = w_win;
          w_addr_next  = w_addr[w_win];
          w_extra_next = w_extra[w_win];
          w_lo_next    = w_lo[w_win];
          w_hi_next    = w_hi[w_win];
        end
      end
      ISSUE: begin
        w_state_next = RESP;
      end
      RESP: begin
        if (w_req[w_other]) begin
          w_state_next = ISSUE;
          w_grant_next = w_other ? 2'b10 : 2'b01;
          w_last_next  = w_other;
          w_addr_next  = w_addr[w_other];
          w_extra_next = w_extra[w_other];
          w_lo_next    = w_lo[w_other];
          w_hi_next    = w_hi[w_other];
        end else begin
          w_state_next = IDLE;
          w_grant_next = 2'b00;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_grant_next = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= 2'b00;
      r_last  <= 1'b1;
      r_addr  <= '0;
      r_extra <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
      r_last  <= w_last_next;
      r_addr  <= w_addr_next;
      r_extra <= w_extra_next;
      r_lo    <= w_lo_next;
      r_hi    <= w_hi_next;
    end
  end

  // ROM request is presented only in ISSUE; its data comes back during RESP.
  assign bus.mem_addr        = (r_state == ISSUE) ? r_addr  : '0;
  assign bus.mem_extra       = (r_state == ISSUE) ? r_extra : '0;
  assign bus.mem_lower_bound = (r_state == ISSUE) ? r_lo    : '0;
  assign bus.mem_upper_bound = (r_state == ISSUE) ? r_hi    : '0;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      assign w_rvalid[gi] = (r_state == RESP) && r_grant[gi];
      assign w_rerror[gi] = w_rvalid[gi] & bus.mem_error;
      assign w_rdata[gi]  = w_rvalid[gi] ? bus.mem_data : '0;
    end
  endgenerate

  assign bus.rvalid0 = w_rvalid[0];
  assign bus.rvalid1 = w_rvalid[1];
  assign bus.rerror0 = w_rerror[0];
  assign bus.rerror1 = w_rerror[1];
  assign bus.rdata0  = w_rdata[0];
  assign bus.rdata1  = w_rdata[1];
  assign bus.busy    = (r_state != IDLE);
  assign bus.grant   = r_grant;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency ROM model that flags
// out-of-bounds addresses.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW    = 4;
  localparam int EXTRA = 4;
  localparam int DW    = (2**EXTRA)*8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if #(.AW(AW), .EXTRA(EXTRA)) bus ();

  mem_arbiter #(.AW(AW), .EXTRA(EXTRA)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input logic [AW:0] a);
    logic [DW-1:0] w;
    for (int i = 0; i < DW/8; i++) w[i*8 +: 8] = {3'b000, a} ^ (8'hA0 + 8'(i));
    return w;
  endfunction

  always @(posedge clk) begin
    bus.mem_data  <= rom_word(bus.mem_addr);
    bus.mem_error <= (bus.mem_addr < bus.mem_lower_bound) || (bus.mem_addr > bus.mem_upper_bound);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    $display("test_reset: outputs during reset");
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end checks++;
    if (bus.grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", bus.grant); end checks++;
    if ({bus.rvalid1, bus.rvalid0} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", {bus.rvalid1, bus.rvalid0}); end checks++;
    if ({bus.rerror1, bus.rerror0} !== 2'b00) begin errors++; $display("FAIL reset_rerror: got %b want 00", {bus.rerror1, bus.rerror0}); end checks++;
    if (bus.rdata0 !== '0 || bus.rdata1 !== '0) begin errors++; $display("FAIL reset_rdata: got %h / %h want 0", bus.rdata0, bus.rdata1); end checks++;
    if (bus.mem_addr !== '0 || bus.mem_upper_bound !== '0 || bus.mem_lower_bound !== '0 || bus.mem_extra !== '0) begin
      errors++; $display("FAIL reset_mem_req: addr %h lo %h hi %h extra %h want all 0", bus.mem_addr, bus.mem_lower_bound, bus.mem_upper_bound, bus.mem_extra);
    end checks++;
    reset = 1'b0;
    step();
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_no_req_busy: got %0b want 0", bus.busy); end checks++;
  endtask

  task automatic test_single_fetch();
    $display("test_single_fetch: port 0 addr 3");
    bus.req0 = 1'b1; bus.addr0 = 5'd3; bus.extra0 = 4'h9; bus.lo0 = 5'd0; bus.hi0 = 5'd31;
    step();
    if (bus.busy !== 1'b1 || bus.grant !== 2'b01) begin errors++; $display("FAIL single_issue_grant: busy %0b grant %b want 1 01", bus.busy, bus.grant); end checks++;
    if (bus.mem_addr !== 5'd3 || bus.mem_extra !== 4'h9 || bus.mem_lower_bound !== 5'd0 || bus.mem_upper_bound !== 5'd31) begin
      errors++; $display("FAIL single_issue_mem: addr %0d extra %h lo %0d hi %0d want 3 9 0 31", bus.mem_addr, bus.mem_extra, bus.mem_lower_bound, bus.mem_upper_bound);
    end checks++;
    if (bus.rvalid0 !== 1'b0) begin errors++; $display("FAIL single_issue_rvalid: got %0b want 0", bus.rvalid0); end checks++;
    step();
    if (bus.rvalid0 !== 1'b1 || bus.rvalid1 !== 1'b0) begin errors++; $display("FAIL single_resp_rvalid: got %b want 01", {bus.rvalid1, bus.rvalid0}); end checks++;
    if (bus.rdata0 !== rom_word(5'd3)) begin errors++; $display("FAIL single_resp_rdata: got %h want %h", bus.rdata0, rom_word(5'd3)); end checks++;
    if (bus.rerror0 !== 1'b0) begin errors++; $display("FAIL single_resp_rerror: got %0b want 0", bus.rerror0); end checks++;
    bus.req0 = 1'b0;
    step();
    if (bus.busy !== 1'b0 || bus.grant !== 2'b00) begin errors++; $display("FAIL single_back_idle: busy %0b grant %b want 0 00", bus.busy, bus.grant); end checks++;
    if (bus.rvalid0 !== 1'b0 || bus.rdata0 !== '0 || bus.mem_addr !== '0) begin
      errors++; $display("FAIL single_idle_outputs: rvalid0 %0b rdata0 %h mem_addr %h want 0", bus.rvalid0, bus.rdata0, bus.mem_addr);
    end checks++;
  endtask

  task automatic test_simultaneous();
    $display("test_simultaneous: both ports after reset");
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.req0 = 1'b1; bus.addr0 = 5'd2; bus.lo0 = 5'd0; bus.hi0 = 5'd31;
    bus.req1 = 1'b1; bus.addr1 = 5'd9; bus.lo1 = 5'd0; bus.hi1 = 5'd31;
    step();
    if (bus.grant !== 2'b01 || bus.busy !== 1'b1) begin errors++; $display("FAIL sim_n1: grant %b busy %0b want 01 1", bus.grant, bus.busy); end checks++;
    step();
    if ({bus.rvalid1, bus.rvalid0} !== 2'b01 || bus.rdata0 !== rom_word(5'd2)) begin
      errors++; $display("FAIL sim_n2: rvalid %b rdata0 %h want 01 %h", {bus.rvalid1, bus.rvalid0}, bus.rdata0, rom_word(5'd2));
    end checks++;
    bus.req0 = 1'b0;
    step();
    if (bus.grant !== 2'b10 || bus.busy !== 1'b1 || bus.mem_addr !== 5'd9) begin
      errors++; $display("FAIL sim_n3: grant %b busy %0b mem_addr %0d want 10 1 9", bus.grant, bus.busy, bus.mem_addr);
    end checks++;
    if ({bus.rvalid1, bus.rvalid0} !== 2'b00) begin errors++; $display("FAIL sim_n3_rvalid: got %b want 00", {bus.rvalid1, bus.rvalid0}); end checks++;
    step();
    if ({bus.rvalid1, bus.rvalid0} !== 2'b10 || bus.rdata1 !== rom_word(5'd9) || bus.busy !== 1'b1) begin
      errors++; $display("FAIL sim_n4: rvalid %b busy %0b rdata1 %h want 10 1 %h", {bus.rvalid1, bus.rvalid0}, bus.busy, bus.rdata1, rom_word(5'd9));
    end checks++;
    bus.req1 = 1'b0;
    step();
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL sim_n5_busy: got %0b want 0", bus.busy); end checks++;
  endtask

  task automatic test_fairness();
    int nresp = 0;
    int port;
    $display("test_fairness: both ports held for 8 responses");
    bus.req0 = 1'b1; bus.addr0 = 5'd5;  bus.lo0 = 5'd0; bus.hi0 = 5'd31;
    bus.req1 = 1'b1; bus.addr1 = 5'd12; bus.lo1 = 5'd0; bus.hi1 = 5'd31;
    for (int cyc = 0; cyc < 40 && nresp < 8; cyc++) begin
      step();
      if (bus.rvalid0 === 1'b1 && bus.rvalid1 === 1'b1) begin errors++; $display("FAIL fair_both_rvalid: cycle %0d both rvalid high", cyc); end checks++;
      if (bus.rvalid0 === 1'b1 || bus.rvalid1 === 1'b1) begin
        port = (bus.rvalid1 === 1'b1) ? 1 : 0;
        $display("  response %0d on port %0d at cycle %0d", nresp, port, cyc);
        if (port != nresp % 2) begin errors++; $display("FAIL fair_order: response %0d port %0d want %0d", nresp, port, nresp % 2); end checks++;
        if (port == 0 && bus.rdata0 !== rom_word(5'd5)) begin errors++; $display("FAIL fair_rdata0: got %h want %h", bus.rdata0, rom_word(5'd5)); end
        if (port == 1 && bus.rdata1 !== rom_word(5'd12)) begin errors++; $display("FAIL fair_rdata1: got %h want %h", bus.rdata1, rom_word(5'd12)); end
        checks++;
        nresp++;
        if (nresp == 8) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      end
    end
    if (nresp != 8) begin errors++; $display("FAIL fair_timeout: got %0d responses want 8", nresp); end checks++;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    step();
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL fair_end_idle: busy %0b want 0", bus.busy); end checks++;
  endtask

  task automatic test_bounds_error();
    $display("test_bounds_error: port 1 addr 20 bounds 0..15");
    bus.req1 = 1'b1; bus.addr1 = 5'd20; bus.extra1 = 4'h3; bus.lo1 = 5'd0; bus.hi1 = 5'd15;
    step();
    if (bus.grant !== 2'b10 || bus.mem_addr !== 5'd20 || bus.mem_upper_bound !== 5'd15 || bus.mem_lower_bound !== 5'd0 || bus.mem_extra !== 4'h3) begin
      errors++; $display("FAIL bounds_issue: grant %b addr %0d lo %0d hi %0d extra %h want 10 20 0 15 3", bus.grant, bus.mem_addr, bus.mem_lower_bound, bus.mem_upper_bound, bus.mem_extra);
    end checks++;
    step();
    if ({bus.rvalid1, bus.rvalid0} !== 2'b10 || bus.rerror1 !== 1'b1 || bus.rerror0 !== 1'b0) begin
      errors++; $display("FAIL bounds_resp: rvalid %b rerror %b want 10 10", {bus.rvalid1, bus.rvalid0}, {bus.rerror1, bus.rerror0});
    end checks++;
    if (bus.rdata1 !== rom_word(5'd20)) begin errors++; $display("FAIL bounds_rdata: got %h want %h", bus.rdata1, rom_word(5'd20)); end checks++;
    bus.req1 = 1'b0;
    step();
    if (bus.busy !== 1'b0 || bus.rerror1 !== 1'b0) begin errors++; $display("FAIL bounds_idle: busy %0b rerror1 %0b want 0 0", bus.busy, bus.rerror1); end checks++;
  endtask

  task automatic test_reset_mid_access();
    $display("test_reset_mid_access: reset in ISSUE with req0 held");
    bus.req0 = 1'b1; bus.addr0 = 5'd6; bus.lo0 = 5'd0; bus.hi0 = 5'd31;
    step();
    if (bus.grant !== 2'b01) begin errors++; $display("FAIL rst_mid_issue: grant %b want 01", bus.grant); end checks++;
    reset = 1'b1;
    step();
    if (bus.rvalid0 !== 1'b0 || bus.rdata0 !== '0 || bus.busy !== 1'b0 || bus.grant !== 2'b00 || bus.mem_addr !== '0) begin
      errors++; $display("FAIL rst_mid_abort: rvalid0 %0b rdata0 %h busy %0b grant %b mem_addr %h want all 0", bus.rvalid0, bus.rdata0, bus.busy, bus.grant, bus.mem_addr);
    end checks++;
    reset = 1'b0;
    step();
    if (bus.rvalid0 !== 1'b0 || bus.grant !== 2'b01) begin errors++; $display("FAIL rst_mid_reissue: rvalid0 %0b grant %b want 0 01", bus.rvalid0, bus.grant); end checks++;
    step();
    if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== rom_word(5'd6)) begin
      errors++; $display("FAIL rst_mid_reserve: rvalid0 %0b rdata0 %h want 1 %h", bus.rvalid0, bus.rdata0, rom_word(5'd6));
    end checks++;
    bus.req0 = 1'b0;
    step();
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: busy %0b want 0", bus.busy); end checks++;
  endtask

  task automatic test_withdrawn();
    $display("test_withdrawn: req1 pulsed during port 0 access");
    bus.req0 = 1'b1; bus.addr0 = 5'd1; bus.lo0 = 5'd0; bus.hi0 = 5'd31;
    step();
    bus.req1 = 1'b1; bus.addr1 = 5'd4; bus.lo1 = 5'd0; bus.hi1 = 5'd31;
    step();
    if ({bus.rvalid1, bus.rvalid0} !== 2'b01) begin errors++; $display("FAIL wd_resp0: rvalid %b want 01", {bus.rvalid1, bus.rvalid0}); end checks++;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    step();
    if (bus.busy !== 1'b0 || bus.grant !== 2'b00 || bus.rvalid1 !== 1'b0) begin
      errors++; $display("FAIL wd_idle: busy %0b grant %b rvalid1 %0b want 0 00 0", bus.busy, bus.grant, bus.rvalid1);
    end checks++;
    step();
    step();
    if (bus.rvalid1 !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL wd_dropped: rvalid1 %0b busy %0b want 0 0", bus.rvalid1, bus.busy); end checks++;
  endtask

  initial begin
    reset = 1'b1;
    bus.req0 = 1'b0; bus.addr0 = '0; bus.extra0 = '0; bus.lo0 = '0; bus.hi0 = '0;
    bus.req1 = 1'b0; bus.addr1 = '0; bus.extra1 = '0; bus.lo1 = '0; bus.hi1 = '0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_fairness();
    test_bounds_error();
    test_reset_mid_access();
    test_withdrawn();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
